// File: rtl/multimode_led_counter.sv
// rtl/multimode_led_counter.sv - prescaled LED counter with up/down/bounce/Gray modes and load
module multimode_led_counter #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24
) (
    input  logic             wClk,
    input  logic             wRst,
    input  logic             iEn,
    input  logic [1:0]       iMode,
    input  logic [DIV_W-1:0] iDiv,
    input  logic [WIDTH-1:0] iLimit,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iLoadVal,
    output logic [WIDTH-1:0] rOutCount,
    output logic             oTick,
    output logic             oWrap
);

    typedef enum logic [1:0] {
        MODE_UP     = 2'd0,
        MODE_DOWN   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_GRAY   = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [DIV_W-1:0] pre, pre_next;
    logic [WIDTH-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] out_next;
    dir_t             dir, dir_next;
    logic             tick_next, wrap_next;
    logic             step;
    mode_t            mode;

    assign mode = mode_t'(iMode);
    assign step = iEn && (pre >= iDiv);

    // State and output registers; reset first, then the precomputed next values
    always_ff @(posedge wClk) begin
        if (wRst) begin
            pre       <= '0;
            cnt       <= '0;
            dir       <= DIR_UP;
            rOutCount <= '0;
            oTick     <= 1'b0;
            oWrap     <= 1'b0;
        end else begin
            pre       <= pre_next;
            cnt       <= cnt_next;
            dir       <= dir_next;
            rOutCount <= out_next;
            oTick     <= tick_next;
            oWrap     <= wrap_next;
        end
    end

    // Next-state: load beats tick; a tick steps the count per mode; Gray only changes encoding
    always_comb begin
        pre_next  = pre;
        cnt_next  = cnt;
        dir_next  = dir;
        tick_next = 1'b0;
        wrap_next = 1'b0;

        if (iLoad) begin
            cnt_next = iLoadVal;
            pre_next = '0;
            dir_next = DIR_UP;
        end else if (iEn) begin
            if (step) begin
                pre_next  = '0;
                tick_next = 1'b1;
                case (mode)
                    MODE_DOWN: begin
                        if (cnt == '0) begin
                            cnt_next  = iLimit;
                            wrap_next = 1'b1;
                        end else if (cnt > iLimit) begin
                            cnt_next = iLimit;
                        end else begin
                            cnt_next = cnt - WIDTH'(1);
                        end
                    end
                    MODE_BOUNCE: begin
                        if (dir == DIR_UP) begin
                            if (cnt >= iLimit) begin
                                // Only reachable at zero when the limit is zero: treat as a bottom turnaround
                                if (cnt == '0) begin
                                    cnt_next  = '0;
                                    wrap_next = 1'b1;
                                end else begin
                                    dir_next = DIR_DOWN;
                                    cnt_next = cnt - WIDTH'(1);
                                end
                            end else begin
                                cnt_next = cnt + WIDTH'(1);
                            end
                        end else begin
                            if (cnt == '0) begin
                                dir_next  = DIR_UP;
                                cnt_next  = {{(WIDTH-1){1'b0}}, (iLimit != '0)};
                                wrap_next = 1'b1;
                            end else begin
                                cnt_next = cnt - WIDTH'(1);
                            end
                        end
                    end
                    default: begin
                        if (cnt >= iLimit) begin
                            cnt_next  = '0;
                            wrap_next = 1'b1;
                        end else begin
                            cnt_next = cnt + WIDTH'(1);
                        end
                    end
                endcase
            end else begin
                pre_next = pre + DIV_W'(1);
            end
        end

        if (mode != MODE_BOUNCE) begin
            dir_next = DIR_UP;
        end

        out_next = (mode == MODE_GRAY) ? (cnt_next ^ (cnt_next >> 1)) : cnt_next;
    end

endmodule

// File: tb/tb_multimode_led_counter.sv
// tb/tb_multimode_led_counter.sv - scoreboard bench with a behavioural counter model
module tb_multimode_led_counter;

    localparam int W = 8;
    localparam int D = 24;

    logic         wClk = 1'b0;
    logic         wRst = 1'b1;
    logic         iEn = 1'b0;
    logic [1:0]   iMode = 2'd0;
    logic [D-1:0] iDiv = '0;
    logic [W-1:0] iLimit = '0;
    logic         iLoad = 1'b0;
    logic [W-1:0] iLoadVal = '0;
    logic [W-1:0] rOutCount;
    logic         oTick;
    logic         oWrap;

    multimode_led_counter #(.WIDTH(W), .DIV_W(D)) dut (
        .wClk      (wClk),
        .wRst      (wRst),
        .iEn       (iEn),
        .iMode     (iMode),
        .iDiv      (iDiv),
        .iLimit    (iLimit),
        .iLoad     (iLoad),
        .iLoadVal  (iLoadVal),
        .rOutCount (rOutCount),
        .oTick     (oTick),
        .oWrap     (oWrap)
    );

    always #5 wClk = ~wClk;

    typedef struct {
        int out;
        int tick;
        int wrap;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_total = 0;
    int   n_pass = 0;

    // reference model state
    int m_pre = 0;
    int m_cnt = 0;
    bit m_up = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // one stimulus cycle: apply inputs, advance the model, queue the expected registered response
    task automatic drive(input bit r, input bit en, input int md, input int dv,
                         input int lim, input bit ld, input int lv);
        exp_t x;
        int tk;
        int wr;
        tk = 0;
        wr = 0;
        @(negedge wClk);
        wRst     = r;
        iEn      = en;
        iMode    = 2'(md);
        iDiv     = D'(dv);
        iLimit   = W'(lim);
        iLoad    = ld;
        iLoadVal = W'(lv);
        if (r) begin
            m_pre = 0;
            m_cnt = 0;
            m_up  = 1'b1;
        end else begin
            if (ld) begin
                m_cnt = lv;
                m_pre = 0;
                m_up  = 1'b1;
            end else if (en) begin
                if (m_pre >= dv) begin
                    tk = 1;
                    m_pre = 0;
                    if (md == 1) begin
                        if (m_cnt == 0) begin m_cnt = lim; wr = 1; end
                        else if (m_cnt > lim) m_cnt = lim;
                        else m_cnt = m_cnt - 1;
                    end else if (md == 2) begin
                        if (m_up) begin
                            if (m_cnt >= lim) begin
                                if (m_cnt == 0) wr = 1;
                                else begin m_up = 1'b0; m_cnt = m_cnt - 1; end
                            end else m_cnt = m_cnt + 1;
                        end else begin
                            if (m_cnt == 0) begin
                                m_up = 1'b1;
                                m_cnt = (lim == 0) ? 0 : 1;
                                wr = 1;
                            end else m_cnt = m_cnt - 1;
                        end
                    end else begin
                        if (m_cnt >= lim) begin m_cnt = 0; wr = 1; end
                        else m_cnt = m_cnt + 1;
                    end
                end else begin
                    m_pre = m_pre + 1;
                end
            end
            if (md != 2) m_up = 1'b1;
        end
        x.out  = r ? 0 : ((md == 3) ? (m_cnt ^ (m_cnt >> 1)) : m_cnt);
        x.tick = tk;
        x.wrap = wr;
        q.push_back(x);
    endtask

    // monitor: every clock the DUT presents a fresh registered response
    always @(posedge wClk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("count", int'(rOutCount), e.out);
            check("tick", int'(oTick), e.tick);
            check("wrap", int'(oWrap), e.wrap);
        end
    end

    initial begin
        // reset, then free-running up count through a full 8-bit wrap
        drive(1, 0, 0, 0, 255, 0, 0);
        drive(1, 0, 0, 0, 255, 0, 0);
        for (int i = 0; i < 300; i++) drive(0, 1, 0, 0, 255, 0, 0);

        // prescaler and small limit, then a freeze with iEn low
        drive(1, 0, 0, 3, 5, 0, 0);
        for (int i = 0; i < 40; i++) drive(0, 1, 0, 3, 5, 0, 0);
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 3, 5, 0, 0);
        for (int i = 0; i < 12; i++) drive(0, 1, 0, 3, 5, 0, 0);
        // lowering iDiv below the running prescaler
        for (int i = 0; i < 6; i++) drive(0, 1, 0, 0, 5, 0, 0);

        // down and bounce from zero
        drive(0, 1, 0, 0, 3, 1, 0);
        for (int i = 0; i < 8; i++) drive(0, 1, 1, 0, 3, 0, 0);
        drive(0, 1, 2, 0, 3, 1, 0);
        for (int i = 0; i < 12; i++) drive(0, 1, 2, 0, 3, 0, 0);
        // bounce with a zero limit
        for (int i = 0; i < 4; i++) drive(0, 1, 2, 0, 0, 0, 0);

        // Gray up to 7
        drive(0, 1, 3, 0, 7, 1, 0);
        for (int i = 0; i < 10; i++) drive(0, 1, 3, 0, 7, 0, 0);

        // load coincident with a tick, then reset beating a load
        drive(0, 1, 0, 0, 255, 1, 200);
        drive(0, 1, 0, 0, 255, 0, 0);
        drive(1, 1, 0, 0, 255, 1, 77);
        drive(0, 1, 0, 0, 255, 0, 0);

        // limit lowered below the count in UP and DOWN
        drive(0, 1, 0, 0, 255, 1, 9);
        drive(0, 1, 0, 0, 2, 0, 0);
        drive(0, 1, 0, 0, 2, 0, 0);
        drive(0, 1, 1, 0, 255, 1, 9);
        drive(0, 1, 1, 0, 2, 0, 0);
        drive(0, 1, 1, 0, 2, 0, 0);

        // randomized mix of every input
        for (int i = 0; i < 2000; i++) begin
            int lim;
            lim = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                  $urandom_range(0, 3), $urandom_range(0, 3), lim,
                  ($urandom_range(0, 19) == 0), $urandom_range(0, 255));
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge wClk);
        #3;
        if (q.size() > 0) check("drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
